// File: rtl/mandel_pkg.sv
// mandel_pkg: shared types and frame geometry for the Mandelbrot scheduler.
// Holds the scheduler state enum plus resolution and datapath widths.
package mandel_pkg;

    localparam int H_RES      = 640;
    localparam int V_RES      = 480;
    localparam int X_WIDTH    = 10;
    localparam int Y_WIDTH    = 9;
    localparam int ADDR_WIDTH = 19;
    localparam int DATA_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/mandel_core_scheduler_if.sv
// mandel_core_scheduler_if: core dispatch/result bus and frame-buffer port.
// master = scheduler side, slave = cores, result mux and frame buffer.
interface mandel_core_scheduler_if
    import mandel_pkg::*;
#(
    parameter int NUM_CORES    = 15,
    parameter int SELECT_WIDTH = 4
) ();

    logic [NUM_CORES-1:0]    core_done;
    logic [DATA_WIDTH-1:0]   mux_q;
    logic [NUM_CORES-1:0]    o_core_start;
    logic [X_WIDTH-1:0]      o_x;
    logic [Y_WIDTH-1:0]      o_y;
    logic [NUM_CORES-1:0]    o_core_ack;
    logic [SELECT_WIDTH-1:0] o_select;
    logic                    o_wr_en;
    logic [ADDR_WIDTH-1:0]   o_wr_addr;
    logic [DATA_WIDTH-1:0]   o_wr_data;

    modport master (
        input  core_done, mux_q,
        output o_core_start, o_x, o_y, o_core_ack,
        output o_select, o_wr_en, o_wr_addr, o_wr_data
    );

    modport slave (
        output core_done, mux_q,
        input  o_core_start, o_x, o_y, o_core_ack,
        input  o_select, o_wr_en, o_wr_addr, o_wr_data
    );

endinterface

// File: rtl/mandel_core_scheduler_rr_arbiter.sv
// rr_arbiter: rotating-priority arbiter, one grant per cycle.
// Search starts at the pointer; the pointer moves past each winner.
module rr_arbiter #(
    parameter int N = 15,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic [W-1:0] index,
    output logic         valid
);

    logic [W-1:0] ptr;

    // Pick the first request found scanning upward from the pointer
    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[(int'(ptr) + i) % N]) begin
                valid = 1'b1;
                grant[(int'(ptr) + i) % N] = 1'b1;
                index = W'((int'(ptr) + i) % N);
            end
        end
    end

    // Advance the pointer to one past the winner, wrapping at N-1
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (valid) begin
            ptr <= (int'(index) == N - 1) ? '0 : index + 1'b1;
        end
    end

endmodule

// File: rtl/mandel_core_scheduler.sv
// mandel_core_scheduler: raster pixel dispatch and round-robin collection.
// Optional MANDEL_PERF_CNT_EN adds the o_frame_cycles frame-cycle counter.
module mandel_core_scheduler #(
    parameter int NUM_CORES    = 15,
    parameter int SELECT_WIDTH = 4,
    parameter int H_RES        = mandel_pkg::H_RES,
    parameter int V_RES        = mandel_pkg::V_RES
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    mandel_core_scheduler_if.master bus,
    output logic o_busy,
    output logic o_frame_done
`ifdef MANDEL_PERF_CNT_EN
    ,
    output logic [31:0] o_frame_cycles
`endif
);

    import mandel_pkg::*;

    state_t state, state_n;

    logic [NUM_CORES-1:0]    owned;
    logic [NUM_CORES-1:0]    inflight;
    logic [ADDR_WIDTH-1:0]   tag [NUM_CORES];
    logic [X_WIDTH-1:0]      x;
    logic [Y_WIDTH-1:0]      y;
    logic [ADDR_WIDTH-1:0]   lin;
    logic                    pend;
    logic [SELECT_WIDTH-1:0] pend_idx;

    logic [NUM_CORES-1:0]    free_pick;
    logic                    disp;
    logic                    last_px;
    logic                    collecting;
    logic [NUM_CORES-1:0]    req;
    logic [NUM_CORES-1:0]    gnt;
    logic [SELECT_WIDTH-1:0] gidx;
    logic                    gvalid;

    // Lowest free core, dispatch enable and end-of-frame pixel detect
    always_comb begin
        free_pick  = ~owned & (owned + 1'b1);
        disp       = (state == RUN) && (free_pick != '0);
        last_px    = (x == X_WIDTH'(H_RES - 1)) &&
                     (y == Y_WIDTH'(V_RES - 1));
        collecting = (state == RUN) || (state == DRAIN);
        req        = collecting ?
                     (bus.core_done & owned & ~inflight) : '0;
    end

    rr_arbiter #(
        .N(NUM_CORES),
        .W(SELECT_WIDTH)
    ) u_arb (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .grant(gnt),
        .index(gidx),
        .valid(gvalid)
    );

    // Next-state and status decode
    always_comb begin
        state_n      = state;
        o_busy       = (state != IDLE);
        o_frame_done = (state == DONE);
        unique case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (disp && last_px) state_n = DRAIN;
            DRAIN:   if (owned == '0 && inflight == '0 && !pend)
                         state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Dispatch, collection pipeline and ownership bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            owned            <= '0;
            inflight         <= '0;
            x                <= '0;
            y                <= '0;
            lin              <= '0;
            pend             <= 1'b0;
            pend_idx         <= '0;
            bus.o_core_start <= '0;
            bus.o_x          <= '0;
            bus.o_y          <= '0;
            bus.o_core_ack   <= '0;
            bus.o_select     <= '0;
            bus.o_wr_en      <= 1'b0;
            bus.o_wr_addr    <= '0;
            bus.o_wr_data    <= '0;
            for (int k = 0; k < NUM_CORES; k++) tag[k] <= '0;
        end else begin
            bus.o_core_start <= '0;
            bus.o_core_ack   <= '0;
            bus.o_wr_en      <= 1'b0;
            if (state == IDLE && start) begin
                x   <= '0;
                y   <= '0;
                lin <= '0;
            end
            if (disp) begin
                bus.o_core_start <= free_pick;
                bus.o_x          <= x;
                bus.o_y          <= y;
                lin              <= lin + 1'b1;
                if (x == X_WIDTH'(H_RES - 1)) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            for (int k = 0; k < NUM_CORES; k++)
                if (disp && free_pick[k]) tag[k] <= lin;
            if (gvalid) bus.o_select <= gidx;
            pend     <= gvalid;
            pend_idx <= gidx;
            if (pend) begin
                bus.o_wr_en    <= 1'b1;
                bus.o_wr_data  <= bus.mux_q;
                bus.o_wr_addr  <= tag[pend_idx];
                bus.o_core_ack <= NUM_CORES'(1) << pend_idx;
            end
            owned    <= (owned | (disp ? free_pick : '0)) &
                        ~bus.o_core_ack;
            inflight <= (inflight | gnt) & ~bus.o_core_ack;
        end
    end

`ifdef MANDEL_PERF_CNT_EN
    // Frame cycle counter: cleared on start, saturating over RUN+DRAIN
    always_ff @(posedge clk) begin
        if (reset) begin
            o_frame_cycles <= '0;
        end else if (state == IDLE && start) begin
            o_frame_cycles <= '0;
        end else if (collecting && o_frame_cycles != '1) begin
            o_frame_cycles <= o_frame_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mandel_core_scheduler.sv
// tb_mandel_core_scheduler: directed + randomized bench with a core model.
// Small frame geometry keeps whole-frame runs short.
module tb_mandel_core_scheduler;

    localparam int NC   = 15;
    localparam int SW   = 4;
    localparam int DW   = 12;
    localparam int HT   = 20;
    localparam int VT   = 7;
    localparam int NPIX = HT * VT;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic o_busy;
    logic o_frame_done;
`ifdef MANDEL_PERF_CNT_EN
    logic [31:0] o_frame_cycles;
`endif

    mandel_core_scheduler_if #(.NUM_CORES(NC), .SELECT_WIDTH(SW)) bus ();

    logic [DW-1:0] cres [16];
    assign bus.mux_q = cres[bus.o_select];

    mandel_core_scheduler #(
        .NUM_CORES(NC), .SELECT_WIDTH(SW), .H_RES(HT), .V_RES(VT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .bus         (bus),
        .o_busy      (o_busy),
        .o_frame_done(o_frame_done)
`ifdef MANDEL_PERF_CNT_EN
        ,
        .o_frame_cycles(o_frame_cycles)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int disp_n, wr_n, fd_n, run_cyc;
    bit seen [NPIX];
    bit cbusy [NC];
    int ccnt [NC];
    bit auto_mode;
    int lat_min, lat_max;
    int unsigned s1, s2, s3;

    function automatic logic [DW-1:0] ref_pix(int px, int py);
        return DW'(px * s1 + py * s2 + s3);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        bus.core_done = '0;
        for (int k = 0; k < NC; k++) begin
            cbusy[k] = 1'b0;
            ccnt[k]  = 0;
        end
    endtask

    task automatic new_frame();
        for (int a = 0; a < NPIX; a++) seen[a] = 1'b0;
        disp_n  = 0;
        wr_n    = 0;
        fd_n    = 0;
        run_cyc = 0;
        s1 = $urandom_range(1, 97);
        s2 = $urandom_range(1, 211);
        s3 = $urandom_range(0, 4095);
    endtask

    // One clock: observe registered outputs, check, advance core model
    task automatic step();
        int a;
        @(posedge clk);
        #1;
        if (auto_mode)
            for (int k = 0; k < NC; k++)
                if (cbusy[k] && !bus.core_done[k]) begin
                    ccnt[k]--;
                    if (ccnt[k] <= 0) bus.core_done[k] = 1'b1;
                end
        if (bus.o_wr_en === 1'b1) begin
            a = int'(bus.o_wr_addr);
            chk("wr_range", a < NPIX, 1);
            chk("ack_onehot", $onehot(bus.o_core_ack), 1);
            if (a < NPIX) begin
                chk("wr_dup", seen[a], 0);
                seen[a] = 1'b1;
                chk("wr_data", bus.o_wr_data, ref_pix(a % HT, a / HT));
            end
            wr_n++;
        end
        for (int k = 0; k < NC; k++)
            if (bus.o_core_ack[k] === 1'b1) begin
                cbusy[k] = 1'b0;
                bus.core_done[k] = 1'b0;
            end
        if (bus.o_core_start !== '0 && !$isunknown(bus.o_core_start)) begin
            chk("disp_onehot", $onehot(bus.o_core_start), 1);
            chk("disp_x", bus.o_x, disp_n % HT);
            chk("disp_y", bus.o_y, disp_n / HT);
            disp_n++;
            for (int k = 0; k < NC; k++)
                if (bus.o_core_start[k]) begin
                    chk("disp_free", cbusy[k], 0);
                    cbusy[k] = 1'b1;
                    ccnt[k]  = $urandom_range(lat_max, lat_min);
                    cres[k]  = ref_pix(int'(bus.o_x), int'(bus.o_y));
                end
        end
        if (o_frame_done === 1'b1) fd_n++;
        if (o_busy === 1'b1 && o_frame_done !== 1'b1) run_cyc++;
    endtask

    task automatic check_idle(string tag);
        chk({tag, "_start"}, bus.o_core_start, 0);
        chk({tag, "_x"}, bus.o_x, 0);
        chk({tag, "_y"}, bus.o_y, 0);
        chk({tag, "_ack"}, bus.o_core_ack, 0);
        chk({tag, "_sel"}, bus.o_select, 0);
        chk({tag, "_wren"}, bus.o_wr_en, 0);
        chk({tag, "_addr"}, bus.o_wr_addr, 0);
        chk({tag, "_data"}, bus.o_wr_data, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_fdone"}, o_frame_done, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        step();
        step();
        reset = 1'b0;
    endtask

    // Start a frame, check first dispatch timing, run to frame_done
    task automatic run_frame(bit poke);
        int n;
        bit poked;
        new_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("run_busy", o_busy, 1);
        chk("run_nodisp", bus.o_core_start, 0);
        step();
        chk("first_start", bus.o_core_start, 1);
        chk("first_x", bus.o_x, 0);
        chk("first_y", bus.o_y, 0);
        n = 0;
        poked = 1'b0;
        while (fd_n == 0 && n < 20000) begin
            if (poke && !poked && disp_n == NPIX &&
                o_busy && !o_frame_done) begin
                start = 1'b1;
                poked = 1'b1;
                step();
                start = 1'b0;
            end else begin
                step();
            end
            n++;
        end
        chk("frame_done_seen", fd_n, 1);
        chk("frame_writes", wr_n, NPIX);
        chk("frame_disps", disp_n, NPIX);
        if (poke) chk("drain_poked", poked, 1);
`ifdef MANDEL_PERF_CNT_EN
        chk("perf_cycles", o_frame_cycles, run_cyc);
`endif
        step();
        chk("after_fdone", o_frame_done, 0);
        chk("after_busy", o_busy, 0);
        repeat (5) step();
        chk("idle_busy", o_busy, 0);
        chk("idle_disps", disp_n, NPIX);
        chk("one_fdone", fd_n, 1);
`ifdef MANDEL_PERF_CNT_EN
        chk("perf_hold", o_frame_cycles, run_cyc);
`endif
    endtask

    initial begin
        int n;
        for (int k = 0; k < 16; k++) cres[k] = '0;
        auto_mode = 1'b1;
        lat_min = 3;
        lat_max = 3;
        new_frame();

        do_reset();
        check_idle("rst");
        step();
        check_idle("rst_idle");

        // Whole frame, fixed 3-cycle cores
        run_frame(1'b0);

        // Manual cores: spurious done, full load, round-robin order
        do_reset();
        auto_mode = 1'b0;
        new_frame();
        start = 1'b1;
        bus.core_done[5] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            start = 1'b0;
            if (i == 2) bus.core_done[5] = 1'b0;
            chk("spur_wren", bus.o_wr_en, 0);
            chk("spur_ack", bus.o_core_ack, 0);
        end
        n = 0;
        while (disp_n < NC && n < 100) begin
            step();
            n++;
        end
        chk("fill", disp_n, NC);
        repeat (4) begin
            step();
            chk("stall_start", bus.o_core_start, 0);
            chk("stall_x", bus.o_x, NC - 1);
            chk("stall_y", bus.o_y, 0);
        end
        bus.core_done[3]  = 1'b1;
        bus.core_done[7]  = 1'b1;
        bus.core_done[12] = 1'b1;
        step();
        chk("rr_sel0", bus.o_select, 3);
        chk("rr_wr0", bus.o_wr_en, 0);
        step();
        chk("rr_sel1", bus.o_select, 7);
        chk("rr_addr1", bus.o_wr_addr, 3);
        chk("rr_ack1", bus.o_core_ack, 1 << 3);
        chk("rr_data1", bus.o_wr_data, ref_pix(3, 0));
        step();
        chk("rr_sel2", bus.o_select, 12);
        chk("rr_addr2", bus.o_wr_addr, 7);
        chk("rr_ack2", bus.o_core_ack, 1 << 7);
        chk("rr_nodisp", bus.o_core_start, 0);
        step();
        chk("rr_addr3", bus.o_wr_addr, 12);
        chk("rr_ack3", bus.o_core_ack, 1 << 12);
        chk("redisp3", bus.o_core_start, 1 << 3);
        chk("redisp3_x", bus.o_x, NC);
        step();
        chk("redisp7", bus.o_core_start, 1 << 7);
        step();
        chk("redisp12", bus.o_core_start, 1 << 12);
        chk("sel_hold", bus.o_select, 12);
        chk("rr_writes", wr_n, 3);

        // Reset mid-RUN with 10 cores owned
        do_reset();
        new_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (disp_n < 10 && n < 100) begin
            step();
            n++;
        end
        chk("ten_owned", disp_n, 10);
        reset = 1'b1;
        model_reset();
        step();
        reset = 1'b0;
        check_idle("midrst");

        // Randomized latencies, start pulsed during DRAIN
        auto_mode = 1'b1;
        lat_min = 1;
        lat_max = 9;
        run_frame(1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
